// File: rtl/arb_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux_pkg
// Brief    : Mode encodings, lock-state type and channel-index width helper
//            shared by the arb_mux_nto1 slice.
// Revision : 1.0 - initial release
// ============================================================================
package arb_mux_pkg;

    localparam logic [1:0] MODE_RR    = 2'd0;
    localparam logic [1:0] MODE_PRIO  = 2'd1;
    localparam logic [1:0] MODE_FORCE = 2'd2;

    typedef enum logic [0:0] {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

    // Never returns zero so a 1-channel build still has a legal index vector.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : arb_mux_pkg
`default_nettype wire

// File: rtl/arb_mux_nto1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational rotating-priority arbiter; ptr = 0 gives fixed
//            priority with channel 0 highest.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant
);

    logic [NUM_IN-1:0] w_mask;
    logic [NUM_IN-1:0] w_req_hi;
    logic [NUM_IN-1:0] w_gnt_hi;
    logic [NUM_IN-1:0] w_gnt_all;

    // Requests at or above ptr win first; otherwise wrap to the full set.
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_mask
        assign w_mask[gi] = (SEL_W'(gi) >= ptr);
    end

    assign w_req_hi = req & w_mask;

    always_comb begin
        w_gnt_hi  = '0;
        w_gnt_all = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (w_req_hi[i]) begin
                w_gnt_hi    = '0;
                w_gnt_hi[i] = 1'b1;
            end
            if (req[i]) begin
                w_gnt_all    = '0;
                w_gnt_all[i] = 1'b1;
            end
        end
    end

    assign grant = (|w_req_hi) ? w_gnt_hi : w_gnt_all;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/arb_mux_nto1.sv
`default_nettype none
// ============================================================================
// Module   : arb_mux_nto1
// Brief    : Registered N:1 valid/ready mux with round-robin, fixed-priority
//            and forced-select arbitration. Burst locking via ARB_MUX_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module arb_mux_nto1
    import arb_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic [SEL_W-1:0]        force_sel,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_last,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_sel;
    logic [SEL_W-1:0]  r_ptr;

    logic              w_load;
    logic              w_rr_mode;
    logic [NUM_IN-1:0] w_force_mask;
    logic [NUM_IN-1:0] w_req;
    logic [SEL_W-1:0]  w_arb_ptr;
    logic [NUM_IN-1:0] w_arb_grant;
    logic [NUM_IN-1:0] w_grant;
    logic              w_any;
    logic [SEL_W-1:0]  w_gnt_idx;
    logic [WIDTH-1:0]  w_gnt_data;
    logic [SEL_W-1:0]  w_ptr_next;
    logic              w_gnt_last;

    assign w_load = !r_out_valid || out_ready;

    // An out-of-range force_sel matches no channel, so nothing is eligible.
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_force_mask
        assign w_force_mask[gi] = (SEL_W'(gi) == force_sel);
    end

`ifdef ARB_MUX_LOCK_EN
    lock_state_t       r_lock_state;
    lock_state_t       w_lock_next;
    logic [SEL_W-1:0]  r_lock_ch;
    logic [SEL_W-1:0]  w_lock_ch_next;
    logic [NUM_IN-1:0] w_lock_mask;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lock_mask
        assign w_lock_mask[gi] = (SEL_W'(gi) == r_lock_ch);
    end

    assign w_gnt_last = |(w_grant & in_last);
`else
    logic w_unused_last;
    assign w_unused_last = ^in_last;
    assign w_gnt_last    = 1'b1;
`endif

    always_comb begin
        w_req     = in_valid;
        w_arb_ptr = r_ptr;
        w_rr_mode = 1'b1;
        case (mode)
            MODE_PRIO: begin
                w_arb_ptr = '0;
                w_rr_mode = 1'b0;
            end
            MODE_FORCE: begin
                w_req     = in_valid & w_force_mask;
                w_arb_ptr = '0;
                w_rr_mode = 1'b0;
            end
            default: ;
        endcase
`ifdef ARB_MUX_LOCK_EN
        // A held burst owns the output regardless of the selected mode.
        if (r_lock_state == LOCK_HELD) begin
            w_req = in_valid & w_lock_mask;
        end
`endif
    end

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req   (w_req),
        .ptr   (w_arb_ptr),
        .grant (w_arb_grant)
    );

    assign w_grant  = w_load ? w_arb_grant : '0;
    assign w_any    = |w_grant;
    assign in_ready = w_grant;

    always_comb begin
        w_gnt_idx  = '0;
        w_gnt_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant[i]) begin
                w_gnt_idx  = SEL_W'(i);
                w_gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : (w_gnt_idx + 1'b1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_any && w_rr_mode && w_gnt_last) begin
            r_ptr <= w_ptr_next;
        end
    end

`ifdef ARB_MUX_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_state <= LOCK_IDLE;
            r_lock_ch    <= '0;
        end else begin
            r_lock_state <= w_lock_next;
            r_lock_ch    <= w_lock_ch_next;
        end
    end

    always_comb begin
        w_lock_next    = r_lock_state;
        w_lock_ch_next = r_lock_ch;
        case (r_lock_state)
            LOCK_IDLE: begin
                if (w_any && !w_gnt_last) begin
                    w_lock_next    = LOCK_HELD;
                    w_lock_ch_next = w_gnt_idx;
                end
            end
            LOCK_HELD: begin
                if (w_any && w_gnt_last) begin
                    w_lock_next = LOCK_IDLE;
                end
            end
            default: w_lock_next = LOCK_IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            r_out_valid <= w_any;
            if (w_any) begin
                r_out_data <= w_gnt_data;
                r_out_sel  <= w_gnt_idx;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule : arb_mux_nto1
`default_nettype wire

// File: tb/tb_arb_mux_nto1.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_mux_nto1
// Brief    : Directed self-checking bench for arb_mux_nto1 (4 x 32-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_mux_nto1;

    localparam int C_WIDTH  = 32;
    localparam int C_NUM_IN = 4;
    localparam int C_SEL_W  = 2;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [1:0]                  mode;
    logic [C_SEL_W-1:0]          force_sel;
    logic [C_NUM_IN-1:0]         in_valid;
    logic [C_NUM_IN*C_WIDTH-1:0] in_data;
    logic [C_NUM_IN-1:0]         in_last;
    logic [C_NUM_IN-1:0]         in_ready;
    logic                        out_valid;
    logic [C_WIDTH-1:0]          out_data;
    logic [C_SEL_W-1:0]          out_sel;
    logic                        out_ready;

    int vectors = 0;
    int errors  = 0;

    arb_mux_nto1 #(
        .WIDTH  (C_WIDTH),
        .NUM_IN (C_NUM_IN),
        .SEL_W  (C_SEL_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .force_sel (force_sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks happen there too.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [C_WIDTH-1:0] chan_data(input int ch);
        return 32'hA000_0000 + C_WIDTH'(ch * 32'h11);
    endfunction

    initial begin
        reset     = 1'b1;
        mode      = 2'd0;
        force_sel = '0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < C_NUM_IN; i++) in_data[i*C_WIDTH +: C_WIDTH] = chan_data(i);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_sel",   64'(out_sel),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);

        // Round-robin with every channel requesting: 0,1,2,3,0,1,2,3
        in_valid = 4'b1111;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("rr_in_ready", 64'(in_ready), 64'(4'b0001 << (k % 4)));
            step();
            chk("rr_out_valid", 64'(out_valid), 64'd1);
            chk("rr_out_sel",   64'(out_sel),   64'(k % 4));
            chk("rr_out_data",  64'(out_data),  64'(chan_data(k % 4)));
        end

        // Backpressure holding channel 3; release grants channel 0 next
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            step();
            chk("bp_out_sel",  64'(out_sel),  64'd3);
            chk("bp_out_data", 64'(out_data), 64'(chan_data(3)));
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_in_ready", 64'(in_ready), 64'b0001);
        step();
        chk("bp_rel_out_sel", 64'(out_sel), 64'd0);
        chk("bp_next_in_ready", 64'(in_ready), 64'b0010);

        // Fixed priority: channel 1 always beats channel 3
        mode     = 2'd1;
        in_valid = 4'b1010;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("prio_in_ready", 64'(in_ready), 64'b0010);
            step();
            chk("prio_out_sel", 64'(out_sel), 64'd1);
        end

        // Forced select of channel 2
        mode      = 2'd2;
        force_sel = 2'd2;
        in_valid  = 4'b1111;
        in_data[2*C_WIDTH +: C_WIDTH] = 32'hDEADBEEF;
        #1;
        chk("force_in_ready", 64'(in_ready), 64'b0100);
        step();
        chk("force_out_data",  64'(out_data),  64'hDEADBEEF);
        chk("force_out_sel",   64'(out_sel),   64'd2);
        chk("force_out_valid", 64'(out_valid), 64'd1);
        in_valid = 4'b1011;
        #1;
        chk("force_idle_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("force_idle_out_valid", 64'(out_valid), 64'd0);
        in_data[2*C_WIDTH +: C_WIDTH] = chan_data(2);

        // Reset while the output register is full
        mode     = 2'd0;
        in_valid = 4'b1111;
        step();
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        step();
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_data",  64'(out_data),  64'd0);
        chk("mid_rst_out_sel",   64'(out_sel),   64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'b0001);
        step();
        chk("post_rst_out_sel",  64'(out_sel),  64'd0);
        chk("post_rst_out_data", 64'(out_data), 64'(chan_data(0)));

        // Reserved mode 3 continues round-robin from ptr = 1
        mode = 2'd3;
        #1;
        chk("mode3_in_ready", 64'(in_ready), 64'b0010);
        step();
        chk("mode3_out_sel", 64'(out_sel), 64'd1);

`ifdef ARB_MUX_LOCK_EN
        // Channel 1 3-beat burst while channel 2 waits: 1,1,1,2
        mode     = 2'd0;
        in_valid = '0;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 4'b0110;
        in_last  = 4'b0000;
        #1;
        for (int k = 0; k < 3; k++) begin
            in_last = (k == 2) ? 4'b0010 : 4'b0000;
            #1;
            chk("lock_in_ready", 64'(in_ready), 64'b0010);
            step();
            chk("lock_out_sel", 64'(out_sel), 64'd1);
        end
        in_last  = 4'b0000;
        in_valid = 4'b0100;
        #1;
        chk("lock_rel_in_ready", 64'(in_ready), 64'b0100);
        step();
        chk("lock_rel_out_sel", 64'(out_sel), 64'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_arb_mux_nto1
`default_nettype wire
